seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/sevseg_pkg.sv | 21 ++
 rtl/seven_segment_scanner_if.sv | 24 ++
 rtl/hex_to_seg.sv | 12 +
 rtl/seven_segment_scanner.sv | 190 +++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sevseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 0 is the right-most entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Load handshake bundle for the seven-segment scanner.
// Master offers data/dp with valid, slave answers with ready.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS*4-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic                    load_valid;
  logic                    load_ready;

  modport master (
    output load_data,
    output load_dp,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_dp,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment decoder.
// Pure table lookup, no state.
module hex_to_seg
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with shadow-buffered load.
// Optional: SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scanner
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [NUM_DIGITS-1:0] blank,
  seven_segment_scanner_if.slave ld,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = NUM_DIGITS * 4;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] CNT_END = 8'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic                  tick_q;
  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  from_drv_q, from_drv_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [DW-1:0]         pnd_data_q, pnd_data_d;
  logic [NUM_DIGITS-1:0] pnd_dp_q, pnd_dp_d;
  logic                  pnd_q, pnd_d;
  logic                  rdy_q, rdy_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpn_q, dpn_d;
  logic                  fd_q, fd_d;

  logic                  step;
  logic                  bnd;
  logic                  hs;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_mask;

  assign step = tick ^ tick_q;
  assign hs   = ld.load_valid & rdy_q;
  assign nib  = act_data_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Scan FSM: a step opens a blank gap, the gap ends in the next digit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_drv_d = from_drv_q;
    idx_d      = idx_q;
    bnd        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (step) begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          from_drv_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (step) begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          from_drv_d = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == CNT_END) begin
          state_d = ST_DRIVE;
          if (from_drv_q && idx_q != LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            bnd   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow buffer: pending moves to active only on a frame boundary.
  always_comb begin
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    pnd_data_d = pnd_data_q;
    pnd_dp_d   = pnd_dp_q;
    pnd_d      = pnd_q;
    if (bnd && pnd_q) begin
      act_data_d = pnd_data_q;
      act_dp_d   = pnd_dp_q;
      pnd_d      = 1'b0;
    end
    if (hs) begin
      pnd_data_d = ld.load_data;
      pnd_dp_d   = ld.load_dp;
      pnd_d      = 1'b1;
    end
    rdy_d = ~pnd_d;
    fd_d  = bnd;
  end

  // Leading-zero mask, scanned from the top digit down; digit 0 never set.
  always_comb begin
    lz_mask = '0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    begin : g_lz
      logic run;
      run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        run        = run & (act_data_q[i*4 +: 4] == 4'h0);
        lz_mask[i] = run;
      end
    end
`endif
  end

  // Pad drive from the current state; registered one cycle later.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dpn_d = 1'b1;
    if (state_q == ST_DRIVE) begin
      seg_d = dec_seg;
      dpn_d = ~act_dp_q[idx_q];
      if (!(blank[idx_q] | lz_mask[idx_q])) begin
        an_d = ~(ONE << idx_q);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      from_drv_q <= 1'b0;
      idx_q      <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      pnd_data_q <= '0;
      pnd_dp_q   <= '0;
      pnd_q      <= 1'b0;
      rdy_q      <= 1'b1;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      dpn_q      <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      tick_q     <= tick;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_drv_q <= from_drv_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      pnd_data_q <= pnd_data_d;
      pnd_dp_q   <= pnd_dp_d;
      pnd_q      <= pnd_d;
      rdy_q      <= rdy_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dpn_q      <= dpn_d;
      fd_q       <= fd_d;
    end
  end

  assign ld.load_ready = rdy_q;
  assign an            = an_q;
  assign seg           = seg_q;
  assign dp_n          = dpn_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 2 blank cycles).
// Expected values are hand-decoded from the segment table.
module tb_seven_segment_scanner;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick  = 1'b0;
  logic [3:0] blank = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  seven_segment_scanner_if #(.NUM_DIGITS(4)) ld_if ();

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .blank      (blank),
    .ld         (ld_if.slave),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [15:0] d,
                         input logic [3:0] dp);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    ld_if.load_data  = d;
    ld_if.load_dp    = dp;
    ld_if.load_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ld_if.load_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    ld_if.load_valid = 1'b0;
    check({tag, "_hs"}, 32'(got), 32'd1);
  endtask

  task automatic step_chk(input string tag, input logic [3:0] ean,
                          input logic [6:0] eseg, input logic edp,
                          input logic efd);
    @(posedge clk);
    #1 tick = ~tick;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_gap1"}, 32'(an), 32'hF);
    @(posedge clk);
    #1;
    check({tag, "_gap2"}, 32'(an), 32'hF);
    check({tag, "_fd"}, 32'(frame_done), 32'(efd));
    @(posedge clk);
    #1;
    check({tag, "_an"}, 32'(an), 32'(ean));
    check({tag, "_seg"}, 32'(seg), 32'(eseg));
    check({tag, "_dp"}, 32'(dp_n), 32'(edp));
  endtask

  initial begin
    ld_if.load_data  = '0;
    ld_if.load_dp    = '0;
    ld_if.load_valid = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp_n), 32'd1);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_rdy", 32'(ld_if.load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First frame from IDLE with 12AF, dp on digit 0
    do_load("ld0", 16'h12AF, 4'b0001);
    check("ld0_rdy_low", 32'(ld_if.load_ready), 32'd0);
    step_chk("f0d0", 4'hE, 7'h0E, 1'b0, 1'b1);
    check("f0_rdy_back", 32'(ld_if.load_ready), 32'd1);
    step_chk("f0d1", 4'hD, 7'h08, 1'b1, 1'b0);
    step_chk("f0d2", 4'hB, 7'h24, 1'b1, 1'b0);
    step_chk("f0d3", 4'h7, 7'h79, 1'b1, 1'b0);
    step_chk("f1d0", 4'hE, 7'h0E, 1'b0, 1'b1);

    // Back-to-back loads: second one stalls until the boundary
    do_load("ld1", 16'h3456, 4'b0100);
    check("ld1_rdy_low", 32'(ld_if.load_ready), 32'd0);
    fork
      do_load("ld2", 16'h789B, 4'b0000);
      begin
        step_chk("f1d1", 4'hD, 7'h08, 1'b1, 1'b0);
        step_chk("f1d2", 4'hB, 7'h24, 1'b1, 1'b0);
        step_chk("f1d3", 4'h7, 7'h79, 1'b1, 1'b0);
        step_chk("f2d0", 4'hE, 7'h02, 1'b1, 1'b1);
        step_chk("f2d1", 4'hD, 7'h12, 1'b1, 1'b0);
      end
    join
    step_chk("f2d2", 4'hB, 7'h19, 1'b0, 1'b0);
    step_chk("f2d3", 4'h7, 7'h30, 1'b1, 1'b0);
    step_chk("f3d0", 4'hE, 7'h03, 1'b1, 1'b1);

    // Second step lands in BLANK and must be dropped
    @(posedge clk);
    #1 tick = ~tick;
    @(posedge clk);
    #1 tick = ~tick;
    @(posedge clk);
    #1 check("drop_gap1", 32'(an), 32'hF);
    @(posedge clk);
    #1 check("drop_gap2", 32'(an), 32'hF);
    @(posedge clk);
    #1;
    check("drop_an", 32'(an), 32'hD);
    check("drop_seg", 32'(seg), 32'h10);
    repeat (4) @(posedge clk);
    #1 check("drop_hold", 32'(an), 32'hD);

    // Live blank mask
    step_chk("f3d2", 4'hB, 7'h00, 1'b1, 1'b0);
    blank = 4'b1000;
    step_chk("mask_d3", 4'hF, 7'h78, 1'b1, 1'b0);
    blank = 4'b0000;

    // Reset during DRIVE with an update pending
    do_load("ld3", 16'hFFFF, 4'b1111);
    @(posedge clk);
    #1 rst_n = 1'b0;
    tick = 1'b0;
    #2;
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_seg", 32'(seg), 32'h7F);
    check("mrst_dp", 32'(dp_n), 32'd1);
    check("mrst_rdy", 32'(ld_if.load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step_chk("r0d0", 4'hE, 7'h40, 1'b1, 1'b1);

    // Leading-zero behaviour
    do_load("ld4", 16'h0050, 4'b0000);
    step_chk("r0d1", LZ ? 4'hF : 4'hD, 7'h40, 1'b1, 1'b0);
    step_chk("r0d2", LZ ? 4'hF : 4'hB, 7'h40, 1'b1, 1'b0);
    step_chk("r0d3", LZ ? 4'hF : 4'h7, 7'h40, 1'b1, 1'b0);
    step_chk("r1d0", 4'hE, 7'h40, 1'b1, 1'b1);
    step_chk("r1d1", 4'hD, 7'h12, 1'b1, 1'b0);
    step_chk("r1d2", LZ ? 4'hF : 4'hB, 7'h40, 1'b1, 1'b0);
    step_chk("r1d3", LZ ? 4'hF : 4'h7, 7'h40, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
